mesh_router_sync: RTL and testbench
===================================

// Module: mesh_router_sync
// PURPOSE
//  Clocked, parametrised 5-port mesh router node, the synchronous successor to the CSP mesh routers.
//  Ports: PE, N, E, S, W. Each input has a FIFO of programmable depth. Routing is dimension-ordered (XY or YX, chosen by parameter).
//  Each output has a round-robin arbiter and one registered output stage.
//  Instantiated ROW*COL times by the synchronous mesh top level. Neighbour ports connect point-to-point with valid/ready.
// PARAMETERS
//  WIDTH       15  flit width; flit = {dst_x[X_W-1:0], dst_y[Y_W-1:0], payload}, dst_x in MSBs
//  X_W         2   destination-X field width
//  Y_W         2   destination-Y field width
//  ROW         4   mesh rows (Y extent)
//  COL         4   mesh columns (X extent)
//  X_POS       0   this node's column, 0..COL-1
//  Y_POS       0   this node's row, 0..ROW-1 (Y grows toward North)
//  DEPTH       4   entries per input FIFO, >=2
//  ROUTE_MODE  0   0 = XY (resolve X first), 1 = YX
// PORTS  (port index p: 0=PE 1=N 2=E 3=S 4=W; lane p occupies bits [p*WIDTH +: WIDTH])
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_data    in   5*WIDTH  input flits
//  in_valid   in   5        input flit valid
//  in_ready   out  5        input can accept
//  out_data   out  5*WIDTH  output flits (registered)
//  out_valid  out  5        output flit valid (registered)
//  out_ready  in   5        downstream can accept
//  drop_cnt   out  8        saturating count of dropped out-of-mesh flits
// BEHAVIOUR
//  Reset (rst_n low, async): FIFOs empty; out_valid=0; out_data=0; RR pointers=0; drop_cnt=0; in_ready=1 once rst_n deasserts.
//  Handshake: a transfer happens on a rising edge when valid&ready are both high.
//   - Sender holds data and valid stable until the transfer.
//   - in_ready[p] = !full[p]. It is combinational from the FIFO count and never depends on in_valid.
//  FIFO: push on input transfer; pop when the head wins arbitration and the target output stage loads.
//   - Push and pop in the same cycle leave the count unchanged. Push while full is impossible (ready is 0).
//   - Pointers wrap modulo DEPTH (non-power-of-2 depths are legal).
//  Route compute on each non-empty FIFO head (combinational). XY mode:
//   - dx>X_POS -> E; dx<X_POS -> W.
//   - else dy>Y_POS -> N; dy<Y_POS -> S.
//   - else -> PE.
//   - YX mode swaps the order of the X and Y tests.
//  Out-of-mesh head (dx>=COL or dy>=ROW): popped the cycle it reaches the head, without arbitration; drop_cnt += 1, saturating at 255.
//  Arbitration, per output o, every cycle:
//   - Requesters = heads routed to o.
//   - Output stage o loads when (!out_valid[o] | out_ready[o]) and at least one requester exists.
//   - Winner = first requester at or after rr_ptr[o] in order 0..4, wrapping.
//   - On load, rr_ptr[o] <= winner+1 mod 5. The pointer holds when there is no load.
//   - Arbiters for different outputs are independent; up to 5 flits move per cycle.
//  Output stage: out_valid[o] is set on load and cleared on transfer with no new load.
//   - Back-to-back: a transfer and a new load in the same edge keep out_valid high.
//   - A stalled out_data is held stable.
//  Latency: flit accepted on edge k into an empty FIFO with a free output -> out_valid high after edge k+1 (1 cycle).
//  Throughput: 1 flit/cycle per output; no bubbles under continuous out_ready.
//  Ordering: flits from the same input to the same output leave in arrival order.
//  U-turn (for example W in -> W out) is not checked; it is routed as computed.
//  Reset mid-operation: all in-flight flits are discarded; nothing is emitted after rst_n rises until new input arrives.
// TESTING  (defaults, X_POS=1, Y_POS=1)
//  1. Reset: rst_n low mid-traffic -> out_valid=0, drop_cnt=0 immediately; in_ready=5'b11111 after release.
//  2. PE injects dst(3,1) -> appears on E one cycle later.
//     - With ROUTE_MODE=1, dst(3,2) -> N; with ROUTE_MODE=0, dst(3,2) -> E.
//  3. N, S, W all send to dst(1,1) every cycle, out_ready[0]=1 -> PE output order N,S,W,N,S,W..., 1 flit/cycle.
//  4. out_ready[2]=0, PE streams 6 flits to E -> 1 in the output stage + 4 in the FIFO; in_ready[0]=0 after the 5th accept.
//     - After release: all 6 flits emerge in order.
//  5. Inject dst(3,3) with ROW=3 -> no output, drop_cnt=1. 300 such flits -> drop_cnt=255.
//  6. Simultaneous push/pop at full FIFO with out_ready=1 -> count stays DEPTH-1..DEPTH; no loss or duplication (scoreboard).

Source files
------------

// File: rtl/mesh_router_sync.sv
// mesh_router_sync
//   One node of the synchronous 2-D mesh. There are five ports, indexed
//   p = 0..4 as PE, N, E, S and W. Each input has its own FIFO. The head of
//   every FIFO is routed dimension-ordered: XY or YX, chosen by ROUTE_MODE.
//   Every output has an independent round-robin arbiter that feeds a single
//   registered output stage. A head whose destination lies outside the mesh
//   is dropped, and drop_cnt counts these drops.
//
// Ports (lane p of a packed bus is [p*WIDTH +: WIDTH]):
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    5 input flits, flit = {dst_x, dst_y, payload}
//   in_valid   per-input valid
//   in_ready   per-input ready (= FIFO not full)
//   out_data   5 registered output flits
//   out_valid  per-output registered valid
//   out_ready  per-output downstream ready
//   drop_cnt   saturating count of out-of-mesh flits discarded
module mesh_router_sync #(
  parameter int WIDTH      = 15,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int ROW        = 4,
  parameter int COL        = 4,
  parameter int X_POS      = 0,
  parameter int Y_POS      = 0,
  parameter int DEPTH      = 4,
  parameter int ROUTE_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5*WIDTH-1:0] in_data,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [7:0]         drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] P_PE = 3'd0;
  localparam logic [2:0] P_N  = 3'd1;
  localparam logic [2:0] P_E  = 3'd2;
  localparam logic [2:0] P_S  = 3'd3;
  localparam logic [2:0] P_W  = 3'd4;

  // FIFO storage and state
  logic [WIDTH-1:0]        mem_q [5][DEPTH];
  logic [4:0][PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [4:0][CW-1:0]      cnt_q, cnt_d;

  // Head decode
  logic [4:0][WIDTH-1:0]   head;
  logic [4:0][2:0]         dir;
  logic [4:0]              nonempty, drop_now, push, pop;

  // Arbitration: req[o][p] = input p requests output o
  logic [4:0][4:0]         req;
  logic [4:0][2:0]         win;
  logic [4:0]              found, load;
  logic [4:0][2:0]         rr_q, rr_d;

  // Output stages and drop counter
  logic [4:0]              ov_q, ov_d;
  logic [5*WIDTH-1:0]      od_q, od_d;
  logic [7:0]              drop_q, drop_d;

  function automatic logic off_mesh(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
    return (int'(dx) >= COL) || (int'(dy) >= ROW);
  endfunction

  function automatic logic [2:0] route(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
    int x;
    int y;
    logic [2:0] r;
    x = int'(dx);
    y = int'(dy);
    if (ROUTE_MODE == 0) begin
      if (x > X_POS)      r = P_E;
      else if (x < X_POS) r = P_W;
      else if (y > Y_POS) r = P_N;
      else if (y < Y_POS) r = P_S;
      else                r = P_PE;
    end else begin
      if (y > Y_POS)      r = P_N;
      else if (y < Y_POS) r = P_S;
      else if (x > X_POS) r = P_E;
      else if (x < X_POS) r = P_W;
      else                r = P_PE;
    end
    return r;
  endfunction

  // Returns {found, index} of the first request at or after ptr, wrapping.
  // The scan runs from farthest to nearest so the nearest request wins.
  function automatic logic [3:0] rr_pick(input logic [4:0] rq, input logic [2:0] ptr);
    logic [3:0] r;
    int idx;
    r = '0;
    for (int k = 4; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= 5) idx = idx - 5;
      if (rq[idx[2:0]]) r = {1'b1, idx[2:0]};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [4:0] d);
    logic [8:0] s;
    s = {1'b0, cnt};
    for (int p = 0; p < 5; p++) s = s + 9'(d[p]);
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  // Head decode, ready and route compute
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head[p]     = mem_q[p][rd_q[p]];
      nonempty[p] = (cnt_q[p] != '0);
      in_ready[p] = (cnt_q[p] != CW'(DEPTH));
      push[p]     = in_valid[p] & in_ready[p];
      drop_now[p] = nonempty[p] &
                    off_mesh(head[p][WIDTH-1 -: X_W], head[p][WIDTH-X_W-1 -: Y_W]);
      dir[p]      = route(head[p][WIDTH-1 -: X_W], head[p][WIDTH-X_W-1 -: Y_W]);
    end
  end

  // Per-output arbitration; dropped heads pop without competing
  always_comb begin
    req = '0;
    for (int o = 0; o < 5; o++) begin
      for (int p = 0; p < 5; p++) begin
        req[o][p] = nonempty[p] & ~drop_now[p] & (dir[p] == 3'(o));
      end
    end
    for (int o = 0; o < 5; o++) begin
      {found[o], win[o]} = rr_pick(req[o], rr_q[o]);
      load[o] = found[o] & (~ov_q[o] | out_ready[o]);
    end
    pop = drop_now;
    for (int o = 0; o < 5; o++) begin
      if (load[o]) pop[win[o]] = 1'b1;
    end
  end

  // Next state
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      wr_d[p]  = push[p] ? ptr_inc(wr_q[p]) : wr_q[p];
      rd_d[p]  = pop[p]  ? ptr_inc(rd_q[p]) : rd_q[p];
      cnt_d[p] = cnt_q[p];
      if (push[p] && !pop[p])      cnt_d[p] = cnt_q[p] + CW'(1);
      else if (!push[p] && pop[p]) cnt_d[p] = cnt_q[p] - CW'(1);
    end
    ov_d = ov_q;
    od_d = od_q;
    rr_d = rr_q;
    for (int o = 0; o < 5; o++) begin
      if (load[o]) begin
        ov_d[o]                 = 1'b1;
        od_d[o*WIDTH +: WIDTH]  = head[win[o]];
        rr_d[o]                 = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
      end else if (out_ready[o]) begin
        ov_d[o] = 1'b0;
      end
    end
    drop_d = sat_add(drop_q, drop_now);
  end

  // Registered control, output stage and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      ov_q   <= '0;
      od_q   <= '0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      drop_q <= drop_d;
    end
  end

  // FIFO storage; contents need no reset because the counts gate them
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (push[p]) mem_q[p][wr_q[p]] <= in_data[p*WIDTH +: WIDTH];
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mesh_router_sync.sv
// Bench for mesh_router_sync at node (1,1).
// dut    : XY routing, ROW=3 so that dy=3 is outside the mesh.
// dut_yx : YX routing, ROW=4, DEPTH=3.
// Flit payload = {src_port[2:0], seq[7:0]}.
module tb_mesh_router_sync;
  localparam int W = 15;

  logic           clk;
  logic           rst_n;
  logic [5*W-1:0] in_data, out_data, in_data1, out_data1;
  logic [4:0]     in_valid, in_ready, out_valid, out_ready;
  logic [4:0]     in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]     drop_cnt, drop_cnt1;

  int n_cmp = 0;
  int n_fail = 0;

  mesh_router_sync #(.WIDTH(W), .X_W(2), .Y_W(2), .ROW(3), .COL(4), .X_POS(1), .Y_POS(1),
                     .DEPTH(4), .ROUTE_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt));

  mesh_router_sync #(.WIDTH(W), .X_W(2), .Y_W(2), .ROW(4), .COL(4), .X_POS(1), .Y_POS(1),
                     .DEPTH(3), .ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .drop_cnt(drop_cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input int p, input int dx, input int dy, input int seq);
    return {dx[1:0], dy[1:0], p[2:0], seq[7:0]};
  endfunction

  // Reference route at (1,1): returns the output port, or 5 for a drop
  function automatic int route_ref(input int dx, input int dy, input int yx, input int rows);
    if (dx >= 4 || dy >= rows) return 5;
    if (yx == 0) begin
      if (dx != 1) return (dx > 1) ? 2 : 4;
      if (dy != 1) return (dy > 1) ? 1 : 3;
    end else begin
      if (dy != 1) return (dy > 1) ? 1 : 3;
      if (dx != 1) return (dx > 1) ? 2 : 4;
    end
    return 0;
  endfunction

  // Scoreboard for dut: one queue per (input, output) pair, plus a drop counter
  logic [W-1:0] sbq [25][$];
  int drop_exp;

  always @(negedge clk) begin
    logic [W-1:0] f;
    int s;
    int k;
    int o;
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) sbq[i].delete();
      drop_exp = 0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (in_valid[p] && in_ready[p]) begin
          f = in_data[p*W +: W];
          o = route_ref(int'(f[14:13]), int'(f[12:11]), 0, 3);
          if (o == 5) begin
            if (drop_exp < 255) drop_exp++;
          end else begin
            sbq[p*5+o].push_back(f);
          end
        end
      end
      for (int q = 0; q < 5; q++) begin
        if (out_valid[q] && out_ready[q]) begin
          f = out_data[q*W +: W];
          s = int'(f[10:8]);
          k = s * 5 + q;
          if (s > 4 || sbq[k].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_extra: out %0d got 0x%0h, want no flit", q, f);
          end else begin
            chk("sb_flit", 32'(f), 32'(sbq[k][0]));
            void'(sbq[k].pop_front());
          end
        end
      end
    end
  end

  typedef struct {
    logic yx;
    int   port;
    int   dx;
    int   dy;
    int   want;
  } vec_t;

  initial begin
    vec_t         vecs[16];
    logic [W-1:0] f;
    logic [W-1:0] lane;
    logic [4:0]   ov;
    logic [4:0]   acc;
    logic         a;
    int           nacc, ndrop, seq, r, dx, dy, total;
    int           exps[3];

    exps = '{1, 3, 4};
    vecs[0]  = '{1'b0, 0, 3, 1, 2};
    vecs[1]  = '{1'b0, 0, 3, 2, 2};
    vecs[2]  = '{1'b0, 0, 0, 1, 4};
    vecs[3]  = '{1'b0, 0, 1, 2, 1};
    vecs[4]  = '{1'b0, 0, 1, 0, 3};
    vecs[5]  = '{1'b0, 0, 1, 1, 0};
    vecs[6]  = '{1'b0, 1, 3, 2, 2};
    vecs[7]  = '{1'b0, 3, 0, 0, 4};
    vecs[8]  = '{1'b0, 2, 1, 2, 1};
    vecs[9]  = '{1'b0, 4, 1, 1, 0};
    vecs[10] = '{1'b0, 2, 2, 0, 2};
    vecs[11] = '{1'b0, 0, 3, 3, 5};
    vecs[12] = '{1'b1, 0, 3, 2, 1};
    vecs[13] = '{1'b1, 0, 3, 1, 2};
    vecs[14] = '{1'b1, 0, 0, 0, 3};
    vecs[15] = '{1'b1, 0, 1, 1, 0};

    rst_n = 1'b1;
    in_valid = '0; in_valid1 = '0; in_data = '0; in_data1 = '0;
    out_ready = '1; out_ready1 = '1;
    ndrop = 0; seq = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'h1f);

    // Single-flit routing table
    for (int i = 0; i < 16; i++) begin
      f = mk(vecs[i].port, vecs[i].dx, vecs[i].dy, i);
      if (vecs[i].yx) begin
        in_data1[vecs[i].port*W +: W] = f;
        in_valid1[vecs[i].port] = 1'b1;
      end else begin
        in_data[vecs[i].port*W +: W] = f;
        in_valid[vecs[i].port] = 1'b1;
      end
      step();
      in_valid = '0; in_valid1 = '0;
      ov = vecs[i].yx ? out_valid1 : out_valid;
      chk($sformatf("vec%0d_latency", i), 32'(ov), 0);
      step();
      ov = vecs[i].yx ? out_valid1 : out_valid;
      if (vecs[i].want == 5) begin
        ndrop++;
        chk($sformatf("vec%0d_drop_noout", i), 32'(ov), 0);
        chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(ndrop));
      end else begin
        lane = vecs[i].yx ? out_data1[vecs[i].want*W +: W] : out_data[vecs[i].want*W +: W];
        chk($sformatf("vec%0d_route", i), 32'(ov), 32'(1 << vecs[i].want));
        chk($sformatf("vec%0d_data", i), 32'(lane), 32'(f));
        step();
        ov = vecs[i].yx ? out_valid1 : out_valid;
        chk($sformatf("vec%0d_clear", i), 32'(ov), 0);
      end
    end

    // 300 out-of-mesh flits saturate the drop counter
    nacc = 0;
    in_data[0 +: W] = mk(0, 3, 3, 0);
    in_valid[0] = 1'b1;
    for (int c = 0; c < 1000 && nacc < 300; c++) begin
      a = in_ready[0];
      step();
      if (a) begin
        nacc++;
        in_data[0 +: W] = mk(0, 3, 3, nacc);
      end
    end
    in_valid = '0;
    chk("t5_accepts", 32'(nacc), 300);
    repeat (3) step();
    chk("t5_saturate", 32'(drop_cnt), 255);
    chk("t5_no_output", 32'(out_valid), 0);

    // Asynchronous reset in the middle of traffic
    out_ready = 5'b11011;
    in_data[0 +: W] = mk(0, 3, 1, 0);
    in_valid[0] = 1'b1;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_drop", 32'(drop_cnt), 0);
    chk("midrst_data_zero", 32'(out_data == '0), 1);
    in_valid = '0;
    out_ready = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'h1f);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("midrst_no_emit", 32'(out_valid), 0);
    end

    // N, S, W all target PE: round-robin N,S,W at one flit per cycle
    in_data[1*W +: W] = mk(1, 1, 1, 0);
    in_data[3*W +: W] = mk(3, 1, 1, 0);
    in_data[4*W +: W] = mk(4, 1, 1, 0);
    in_valid = 5'b11010;
    step();
    step();
    for (int c = 0; c < 12; c++) begin
      chk("t3_valid", 32'(out_valid[0]), 1);
      chk("t3_src", 32'(out_data[10:8]), 32'(exps[c % 3]));
      step();
    end
    in_valid = '0;
    repeat (20) step();

    // Stalled E output: 1 in stage + DEPTH in FIFO, then stream through full FIFO
    out_ready[2] = 1'b0;
    nacc = 0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data[0 +: W] = mk(0, 3, 1, nacc);
      a = in_ready[0];
      step();
      if (a) nacc++;
      chk("t4_in_ready", 32'(in_ready[0]), 32'(nacc < 5));
      if (c >= 1) begin
        chk("t4_stage_valid", 32'(out_valid[2]), 1);
        chk("t4_stage_hold", 32'(out_data[2*W +: W]), 32'(mk(0, 3, 1, 0)));
      end
    end
    chk("t4_accepts", 32'(nacc), 5);
    out_ready[2] = 1'b1;
    for (int c = 0; c < 100 && nacc < 25; c++) begin
      in_data[0 +: W] = mk(0, 3, 1, nacc);
      a = in_ready[0];
      step();
      if (a) nacc++;
      chk("t6_no_bubble", 32'(out_valid[2]), 1);
    end
    chk("t6_accepts", 32'(nacc), 25);
    in_valid = '0;
    repeat (10) step();
    chk("t6_drained", 32'(out_valid), 0);

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 1000; c++) begin
      acc = in_valid & in_ready;
      step();
      for (int p = 0; p < 5; p++) begin
        if (!in_valid[p] || acc[p]) begin
          r  = int'($urandom_range(0, 15));
          dy = (r == 0) ? 3 : r % 3;
          dx = int'($urandom_range(0, 3));
          in_data[p*W +: W] = mk(p, dx, dy, seq);
          seq++;
          in_valid[p] = $urandom_range(0, 1) == 1;
        end
      end
      out_ready = 5'($urandom);
    end
    in_valid = '0;
    out_ready = '1;
    repeat (40) step();
    total = 0;
    for (int i = 0; i < 25; i++) total += sbq[i].size();
    chk("final_sb_empty", 32'(total), 0);
    chk("final_drop_cnt", 32'(drop_cnt), 32'(drop_exp));
    chk("final_in_ready", 32'(in_ready), 32'h1f);
    chk("final_out_idle", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
